seg_scan_ctrl: RTL

Time-multiplexed scan controller for a 6-digit common-anode 7-segment display driven through the cascaded HC595 serial driver.
- Takes packed display nibbles, decimal-point, blank and sign controls from the temperature formatter.
- Sequences one digit at a time and emits a 16-bit {segment, digit-select} word plus a one-cycle load strobe to the HC595 driver (its Data / S_EN inputs).
- Captures the input snapshot only at frame start, so the display never tears mid-scan.

---
 rtl/seg_pkg.sv | 27 ++
 rtl/seg7_decode.sv | 16 +
 rtl/seg_scan_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment display blocks.
// - seg_state_e : scan controller FSM states
// - SEG_*       : active-low {g..a} segment codes
// - SEG_TABLE   : nibble -> active-low segment code (hex glyphs 0..F)
// - WORD_BLANK  : HC595 word with every segment dark and no digit selected
package seg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    DWELL = 2'd2
  } seg_state_e;

  localparam logic [6:0]  SEG_BLANK  = 7'h7F;
  localparam logic [6:0]  SEG_MINUS  = 7'h3F;
  localparam logic [15:0] WORD_BLANK = 16'hFF00;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [6:0] seg_lookup(input logic [3:0] nibble);
    return SEG_TABLE[nibble];
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to active-low 7-segment decoder.
// Ports:
//   nibble_i : value 0..F to display
//   seg_n_o  : {g,f,e,d,c,b,a}, 0 = segment lit
module seg7_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_n_o
);

  always_comb begin
    seg_n_o = seg_lookup(nibble_i);
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment display
// fed through a cascaded HC595 serial driver.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   en           : scan enable, 0 blanks the display
//   disp_data    : one nibble per digit, digit 0 in [3:0] (rightmost)
//   dp_mask      : 1 lights the decimal point of that digit
//   blank_mask   : 1 forces that digit blank
//   sign         : 1 shows '-' on the leftmost digit
//   hc_data      : {dp_n, g..a active-low, one-hot digit select}
//   hc_load      : one-cycle strobe telling the driver to ship hc_data
//   digit_idx    : digit currently shown
//   frame_done   : one-cycle pulse after the last digit's dwell
// Inputs are sampled only in the LATCH cycle, so a frame never mixes two snapshots.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIG      = 6,
  parameter int unsigned DWELL_CYCLES = 50000,
  parameter int unsigned LZ_EN        = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [4*NUM_DIG-1:0] disp_data,
  input  logic [NUM_DIG-1:0]   dp_mask,
  input  logic [NUM_DIG-1:0]   blank_mask,
  input  logic                 sign,
  output logic [15:0]          hc_data,
  output logic                 hc_load,
  output logic [2:0]           digit_idx,
  output logic                 frame_done
);

  localparam int unsigned     CntW      = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CntW-1:0] CntReload = CntW'(DWELL_CYCLES - 1);
  localparam logic [2:0]      LastIdx   = 3'(NUM_DIG - 1);

  seg_state_e           state_q, state_d;
  logic [15:0]          hc_data_q, hc_data_d;
  logic                 hc_load_q, hc_load_d;
  logic [2:0]           digit_idx_q, digit_idx_d;
  logic                 frame_done_q, frame_done_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [4*NUM_DIG-1:0] shadow_data_q, shadow_data_d;
  logic [NUM_DIG-1:0]   shadow_dp_q, shadow_dp_d;
  logic [NUM_DIG-1:0]   shadow_blank_q, shadow_blank_d;
  logic                 shadow_sign_q, shadow_sign_d;

  // Word generation. In LATCH the shadows are being loaded on this same edge,
  // so the first word of a frame is built straight from the inputs.
  logic [31:0] src_data;
  logic [7:0]  src_dp;
  logic [7:0]  src_blank;
  logic        src_sign;
  logic [2:0]  next_idx;
  logic [2:0]  word_idx;
  logic [3:0]  word_nib;
  logic [6:0]  dec_seg;
  logic [6:0]  word_seg;
  logic [7:0]  lz_mask;
  logic        zero_chain;
  logic [15:0] word;

  always_comb begin
    if (state_q == LATCH) begin
      src_data  = 32'(disp_data);
      src_dp    = 8'(dp_mask);
      src_blank = 8'(blank_mask);
      src_sign  = sign;
    end else begin
      src_data  = 32'(shadow_data_q);
      src_dp    = 8'(shadow_dp_q);
      src_blank = 8'(shadow_blank_q);
      src_sign  = shadow_sign_q;
    end
  end

  // Index of the word loaded on the next edge: 0 when starting a frame,
  // otherwise the digit after the current one.
  always_comb begin
    next_idx = (digit_idx_q == LastIdx) ? 3'd0 : digit_idx_q + 3'd1;
    word_idx = (state_q == DWELL) ? next_idx : 3'd0;
    word_nib = src_data[{word_idx, 2'b00} +: 4];
  end

  seg7_decode u_decode (
    .nibble_i (word_nib),
    .seg_n_o  (dec_seg)
  );

  // Leading-zero mask: walk down from the top digit while every nibble seen is
  // zero. The sign position is skipped so "-  5" still suppresses the gap.
  always_comb begin
    lz_mask    = '0;
    zero_chain = 1'b1;
    if (LZ_EN != 0) begin
      for (int i = int'(NUM_DIG) - 1; i >= 1; i--) begin
        if (!(src_sign && (i == int'(NUM_DIG) - 1))) begin
          zero_chain = zero_chain & (src_data[4*i +: 4] == 4'h0);
        end
        lz_mask[i] = zero_chain;
      end
    end
  end

  always_comb begin
    if (src_blank[word_idx]) begin
      word_seg = SEG_BLANK;
    end else if (src_sign && (word_idx == LastIdx)) begin
      word_seg = SEG_MINUS;
    end else if (lz_mask[word_idx]) begin
      word_seg = SEG_BLANK;
    end else begin
      word_seg = dec_seg;
    end
    // dp is independent of blanking so a blank digit can still carry a point
    word = {~src_dp[word_idx], word_seg, 8'd1 << word_idx};
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d        = state_q;
    hc_data_d      = hc_data_q;
    hc_load_d      = 1'b0;
    digit_idx_d    = digit_idx_q;
    frame_done_d   = 1'b0;
    cnt_d          = cnt_q;
    shadow_data_d  = shadow_data_q;
    shadow_dp_d    = shadow_dp_q;
    shadow_blank_d = shadow_blank_q;
    shadow_sign_d  = shadow_sign_q;

    if (!en) begin
      state_d     = IDLE;
      hc_data_d   = WORD_BLANK;
      digit_idx_d = 3'd0;
      cnt_d       = '0;
      // one strobe so the driver actually latches the blank word
      hc_load_d   = (state_q != IDLE);
    end else begin
      unique case (state_q)
        IDLE: begin
          hc_data_d = WORD_BLANK;
          state_d   = LATCH;
        end
        LATCH: begin
          shadow_data_d  = disp_data;
          shadow_dp_d    = dp_mask;
          shadow_blank_d = blank_mask;
          shadow_sign_d  = sign;
          digit_idx_d    = 3'd0;
          cnt_d          = CntReload;
          hc_data_d      = word;
          hc_load_d      = 1'b1;
          state_d        = DWELL;
        end
        DWELL: begin
          if (cnt_q == '0) begin
            if (digit_idx_q == LastIdx) begin
              frame_done_d = 1'b1;
              state_d      = LATCH;
            end else begin
              digit_idx_d = next_idx;
              cnt_d       = CntReload;
              hc_data_d   = word;
              hc_load_d   = 1'b1;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: begin
          state_d   = IDLE;
          hc_data_d = WORD_BLANK;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      hc_data_q      <= WORD_BLANK;
      hc_load_q      <= 1'b0;
      digit_idx_q    <= 3'd0;
      frame_done_q   <= 1'b0;
      cnt_q          <= '0;
      shadow_data_q  <= '0;
      shadow_dp_q    <= '0;
      shadow_blank_q <= '0;
      shadow_sign_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      hc_data_q      <= hc_data_d;
      hc_load_q      <= hc_load_d;
      digit_idx_q    <= digit_idx_d;
      frame_done_q   <= frame_done_d;
      cnt_q          <= cnt_d;
      shadow_data_q  <= shadow_data_d;
      shadow_dp_q    <= shadow_dp_d;
      shadow_blank_q <= shadow_blank_d;
      shadow_sign_q  <= shadow_sign_d;
    end
  end

  assign hc_data    = hc_data_q;
  assign hc_load    = hc_load_q;
  assign digit_idx  = digit_idx_q;
  assign frame_done = frame_done_q;

endmodule
